// File: rtl/bufg_gt_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// bufg_gt_div_ctrl_if
// Request/status handshake between a requester and the BUFG_GT divide-ratio
// controller.
//   req_valid  requester -> controller  divide-change request
//   req_div    requester -> controller  requested DIV (0 = pass-through)
//   req_ready  controller -> requester  high only while the controller is idle
//   busy       controller -> requester  high whenever a sequence is running
//   done       controller -> requester  one-cycle completion pulse
//   err        controller -> requester  sticky ratio-check failure
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface bufg_gt_div_ctrl_if;
  logic       req_valid;
  logic [2:0] req_div;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req_valid,
    output req_div,
    input  req_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_div,
    output req_ready,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bufg_gt_div_ctrl.sv
// ---------------------------------------------------------------------------
// bufg_gt_div_ctrl
// Control-side initiator for a BUFG_GT divided clock buffer. Drives CE, CLR
// and DIV from the buffer's source clock and runs a safe ratio change:
// CE off -> CLR pulse carrying the new DIV -> CLR release -> CE on.
//
// Ports
//   clk     in   source clock (same net as the BUFG_GT I input)
//   CLR     in   asynchronous active-high reset
//   req     slave side of bufg_gt_div_ctrl_if (req_valid/req_div in,
//           req_ready/busy/done/err out)
//   gt_ce   out  BUFG_GT CE
//   gt_clr  out  BUFG_GT CLR
//   gt_div  out  BUFG_GT DIV
//   gt_o    in   BUFG_GT O fed back, used only by the ratio checker
//
// Optional feature: define BUFG_GT_RATIO_CHK_EN to enable the CHECK state,
// which measures the divided clock after each change and flags err on a
// wrong ratio or a missing clock. Without it gt_o is ignored and err is 0.
// ---------------------------------------------------------------------------
module bufg_gt_div_ctrl #(
  parameter int unsigned CE_OFF_CYC = 32'd4,
  parameter int unsigned CLR_CYC    = 32'd4,
  parameter int unsigned SETTLE_CYC = 32'd8,
  parameter int unsigned CHK_EDGES  = 32'd4,
  parameter logic [2:0]  RESET_DIV  = 3'd0
) (
  input  logic               clk,
  input  logic               CLR,
  bufg_gt_div_ctrl_if.slave  req,
  output logic               gt_ce,
  output logic               gt_clr,
  output logic [2:0]         gt_div,
  input  logic               gt_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(CE_OFF_CYC, CLR_CYC), SETTLE_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 32'd1);

  // Parameter legality, caught at elaboration.
  if (CE_OFF_CYC < 32'd3) begin : g_bad_ce_off
    $error("bufg_gt_div_ctrl: CE_OFF_CYC must be >= 3");
  end
  if (CLR_CYC < 32'd1) begin : g_bad_clr
    $error("bufg_gt_div_ctrl: CLR_CYC must be >= 1");
  end
  if (SETTLE_CYC < 32'd3) begin : g_bad_settle
    $error("bufg_gt_div_ctrl: SETTLE_CYC must be >= 3");
  end
  if ((CHK_EDGES < 32'd1) || (CHK_EDGES > 32'd15)) begin : g_bad_chk
    $error("bufg_gt_div_ctrl: CHK_EDGES must be in 1..15");
  end

`ifdef BUFG_GT_RATIO_CHK_EN
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CE_OFF  = 3'd2,
    ST_CLR_ON  = 3'd3,
    ST_CLR_REL = 3'd4,
    ST_CE_ON   = 3'd5,
    ST_CHECK   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CE_OFF  = 3'd2,
    ST_CLR_ON  = 3'd3,
    ST_CLR_REL = 3'd4,
    ST_CE_ON   = 3'd5
  } state_t;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             gt_ce_r;
  logic             gt_clr_r;
  logic [2:0]       gt_div_r;
  logic [2:0]       new_div_r;
  logic             req_ready_r;
  logic             busy_r;
  logic             done_pend_r;   // completion seen; done shows one cycle later
  logic             done_r;
  logic             err_r;
  logic             init_seq_r;    // running the post-reset sequence: no done pulse

`ifdef BUFG_GT_RATIO_CHK_EN
  logic       gto_q_r;     // gt_o sampled at posedge clk
  logic       gto_qq_r;    // previous sample, for rising-edge detection
  logic       chk_seen_r;  // first rising edge seen, intervals start counting
  logic [5:0] chk_int_r;   // cycles since last rising edge (or CHECK entry)
  logic [3:0] chk_cnt_r;   // intervals already measured correctly
  logic       rise_s;
  logic [5:0] period_s;
  logic [5:0] limit_s;

  assign rise_s   = gto_q_r & ~gto_qq_r;
  assign period_s = {3'b000, gt_div_r} + 6'd1;
  // No edge within two periods plus margin means the buffer is not toggling.
  assign limit_s  = {period_s[4:0], 1'b0} + 6'd4;

  // Sample the fed-back divided clock on the source clock.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      gto_q_r  <= 1'b0;
      gto_qq_r <= 1'b0;
    end else begin
      gto_q_r  <= gt_o;
      gto_qq_r <= gto_q_r;
    end
  end
`else
  logic unused_gt_o_s;
  assign unused_gt_o_s = gt_o;
`endif

  // Sequencer: state, shared cycle counter and all registered outputs.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_r     <= ST_INIT;
      cnt_r       <= CNT_W'(CLR_CYC - 32'd1);
      gt_ce_r     <= 1'b0;
      gt_clr_r    <= 1'b1;
      gt_div_r    <= RESET_DIV;
      new_div_r   <= RESET_DIV;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b1;
      done_pend_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      init_seq_r  <= 1'b1;
`ifdef BUFG_GT_RATIO_CHK_EN
      chk_seen_r  <= 1'b0;
      chk_int_r   <= 6'd0;
      chk_cnt_r   <= 4'd0;
`endif
    end else begin
      done_r      <= done_pend_r;
      done_pend_r <= 1'b0;
      case (state_r)
        // INIT runs exactly like CLR_ON; only init_seq_r tells them apart.
        ST_INIT, ST_CLR_ON: begin
          if (cnt_r == '0) begin
            state_r  <= ST_CLR_REL;
            gt_clr_r <= 1'b0;
            cnt_r    <= CNT_W'(SETTLE_CYC - 32'd1);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end

        ST_IDLE: begin
          if (req.req_valid && req_ready_r) begin
            err_r     <= 1'b0;
            new_div_r <= req.req_div;
            if (req.req_div == gt_div_r) begin
              // Nothing to change on the buffer; just acknowledge.
              done_pend_r <= 1'b1;
            end else begin
              state_r     <= ST_CE_OFF;
              gt_ce_r     <= 1'b0;
              req_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              cnt_r       <= CNT_W'(CE_OFF_CYC - 32'd1);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_CE_OFF: begin
          if (cnt_r == '0) begin
            // DIV is only ever updated here: CE already low, CLR rising.
            state_r  <= ST_CLR_ON;
            gt_clr_r <= 1'b1;
            gt_div_r <= new_div_r;
            cnt_r    <= CNT_W'(CLR_CYC - 32'd1);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end

        ST_CLR_REL: begin
          if (cnt_r == '0) begin
            state_r <= ST_CE_ON;
            gt_ce_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end

        ST_CE_ON: begin
`ifdef BUFG_GT_RATIO_CHK_EN
          if (!init_seq_r && (gt_div_r != 3'd0)) begin
            state_r    <= ST_CHECK;
            chk_seen_r <= 1'b0;
            chk_int_r  <= 6'd1;
            chk_cnt_r  <= 4'd0;
          end else begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_pend_r <= ~init_seq_r;
            init_seq_r  <= 1'b0;
          end
`else
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          done_pend_r <= ~init_seq_r;
          init_seq_r  <= 1'b0;
`endif
        end

`ifdef BUFG_GT_RATIO_CHK_EN
        ST_CHECK: begin
          if (rise_s) begin
            if (!chk_seen_r) begin
              chk_seen_r <= 1'b1;
              chk_int_r  <= 6'd1;
            end else if (chk_int_r != period_s) begin
              err_r       <= 1'b1;
              state_r     <= ST_IDLE;
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              done_pend_r <= 1'b1;
            end else if (chk_cnt_r == 4'(CHK_EDGES - 32'd1)) begin
              state_r     <= ST_IDLE;
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              done_pend_r <= 1'b1;
            end else begin
              chk_cnt_r <= chk_cnt_r + 4'd1;
              chk_int_r <= 6'd1;
            end
          end else if (chk_int_r >= limit_s) begin
            err_r       <= 1'b1;
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_pend_r <= 1'b1;
          end else begin
            chk_int_r <= chk_int_r + 6'd1;
          end
        end
`endif

        default: begin
          // Unreachable encoding: fall back to the safe post-reset sequence.
          state_r     <= ST_INIT;
          cnt_r       <= CNT_W'(CLR_CYC - 32'd1);
          gt_ce_r     <= 1'b0;
          gt_clr_r    <= 1'b1;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b1;
          init_seq_r  <= 1'b1;
        end
      endcase
    end
  end

  assign gt_ce         = gt_ce_r;
  assign gt_clr        = gt_clr_r;
  assign gt_div        = gt_div_r;
  assign req.req_ready = req_ready_r;
  assign req.busy      = busy_r;
  assign req.done      = done_r;
  assign req.err       = err_r;

endmodule

// File: tb/tb_bufg_gt_div_ctrl.sv
// Scoreboard bench for bufg_gt_div_ctrl: requests push their expected outcome
// (final DIV, err, accept-to-done latency window); a monitor pops on done.
module tb_bufg_gt_div_ctrl;
  localparam int CE_OFF_CYC = 4;
  localparam int CLR_CYC    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int CHK_EDGES  = 4;
  localparam logic [2:0] RESET_DIV = 3'd0;
  localparam int BASE_LAT   = CE_OFF_CYC + CLR_CYC + SETTLE_CYC + 2;

  logic       clk = 1'b0;
  logic       clr;
  logic       gt_ce, gt_clr, gt_o;
  logic [2:0] gt_div;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  bufg_gt_div_ctrl_if bus ();

  bufg_gt_div_ctrl #(
    .CE_OFF_CYC(CE_OFF_CYC), .CLR_CYC(CLR_CYC), .SETTLE_CYC(SETTLE_CYC),
    .CHK_EDGES(CHK_EDGES), .RESET_DIV(RESET_DIV)
  ) dut (
    .clk(clk), .CLR(clr), .req(bus), .gt_ce(gt_ce), .gt_clr(gt_clr),
    .gt_div(gt_div), .gt_o(gt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BUFG_GT: one-cycle-high pulse every N source cycles.
  bit         force_wrong = 1'b0;
  int         bg_cnt = 0;
  logic       bg_o = 1'b0;
  wire  [3:0] bg_n = force_wrong ? ({1'b0, gt_div} + 4'd2) : ({1'b0, gt_div} + 4'd1);
  assign gt_o = bg_o;
  always @(negedge clk) begin
    if (gt_clr === 1'b1) begin
      bg_cnt <= 0;
      bg_o   <= 1'b0;
    end else if (gt_ce === 1'b1) begin
      bg_cnt <= (bg_cnt + 1 >= int'(bg_n)) ? 0 : bg_cnt + 1;
      bg_o   <= (bg_cnt + 1 >= int'(bg_n));
    end else begin
      bg_o <= bg_o;
    end
  end

  typedef struct {
    logic [2:0] div;
    logic       err;
    int         acc;
    int         lat_min;
    int         lat_max;
  } exp_t;
  exp_t       exp_q[$];
  logic [2:0] model_div = RESET_DIV;
  int         last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Monitor: pop one expectation per done pulse; guard DIV-change safety.
  logic [2:0] prev_div = RESET_DIV;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.done, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_gt_div", gt_div, mon_e.div);
          check("done_err", bus.err, mon_e.err);
          check_rng("done_latency", cyc - mon_e.acc, mon_e.lat_min, mon_e.lat_max);
        end
      end
      if (gt_div !== prev_div) check("div_change_ce_clr", {gt_ce, gt_clr}, 2'b01);
    end
    prev_div <= gt_div;
  end

  // Issue one request once the controller is ready; record the expectation.
  task automatic send(input logic [2:0] d);
    exp_t e;
    int   w = 0;
    bit   same;
    while (bus.req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("ready_timeout", bus.req_ready, 1'b1);
    same          = (d == model_div);
    bus.req_valid = 1'b1;
    bus.req_div   = d;
    e.div = d;
    e.acc = cyc + 1;
    e.err = 1'b0;
    if (same) begin
      e.lat_min = 1;
      e.lat_max = 1;
    end else begin
      e.lat_min = BASE_LAT;
      e.lat_max = BASE_LAT;
`ifdef BUFG_GT_RATIO_CHK_EN
      if (d != 3'd0) begin
        e.lat_max = BASE_LAT + (CHK_EDGES + 1) * (int'(d) + 2) + 3;
        e.err     = force_wrong;
      end
`endif
    end
    exp_q.push_back(e);
    model_div = d;
    last_acc  = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Called right after CLR falls at a negedge; times the post-reset sequence.
  task automatic watch_init();
    int clr_fall = -1;
    int ce_rise  = -1;
    int rdy      = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (clr_fall < 0 && gt_clr === 1'b0) clr_fall = i;
      if (ce_rise < 0 && gt_ce === 1'b1) ce_rise = i;
      if (rdy < 0 && bus.req_ready === 1'b1) rdy = i;
    end
    check("init_clr_cycles", clr_fall, CLR_CYC);
    check("init_ce_on", ce_rise, CLR_CYC + SETTLE_CYC);
    check("init_ready", rdy, CLR_CYC + SETTLE_CYC + 1);
    check("init_gt_div", gt_div, RESET_DIV);
  endtask

  task automatic check_reset_vals();
    check("rst_gt_ce", gt_ce, 1'b0);
    check("rst_gt_clr", gt_clr, 1'b1);
    check("rst_gt_div", gt_div, RESET_DIV);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
  endtask

  // Full change sequence timing relative to the accept edge.
  task automatic watch_change(input logic [2:0] d);
    int ce_fall = -1, clr_rise = -1, div_chg = -1, clr_fall = -1, ce_rise = -1;
    send(d);
    for (int i = 0; i < 24; i++) begin
      if (ce_fall < 0 && gt_ce === 1'b0) ce_fall = cyc - last_acc;
      if (clr_rise < 0 && gt_clr === 1'b1) clr_rise = cyc - last_acc;
      if (div_chg < 0 && gt_div === d) div_chg = cyc - last_acc;
      if (clr_rise >= 0 && clr_fall < 0 && gt_clr === 1'b0) clr_fall = cyc - last_acc;
      if (ce_fall >= 0 && ce_rise < 0 && gt_ce === 1'b1) ce_rise = cyc - last_acc;
      @(negedge clk);
    end
    check("chg_ce_fall", ce_fall, 0);
    check("chg_ce_off_len", clr_rise - ce_fall, CE_OFF_CYC);
    check("chg_div_with_clr", div_chg, clr_rise);
    check("chg_clr_len", clr_fall - clr_rise, CLR_CYC);
    check("chg_settle_len", ce_rise - clr_fall, SETTLE_CYC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int toggles;
    int gap;
    logic [2:0] d;
    clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_div   = 3'd0;

    // 1. reset and the init sequence
    repeat (3) @(negedge clk);
    check_reset_vals();
    clr = 1'b0;
    watch_init();

    // 2. full ratio change to 3
    watch_change(3'd3);
    wait_drain();

    // 3. same DIV: immediate done, buffer untouched
    toggles = 0;
    send(3'd3);
    for (int i = 0; i < 5; i++) begin
      if (gt_ce !== 1'b1 || gt_clr !== 1'b0) toggles++;
      @(negedge clk);
    end
    check("same_div_no_toggle", toggles, 0);
    wait_drain();

    // 4. requests while busy are ignored
    send(3'd6);
    bus.req_valid = 1'b1;
    bus.req_div   = 3'd5;
    for (int i = 0; i < 6; i++) begin
      check("busy_req_ready", bus.req_ready, 1'b0);
      check("busy_div_not_5", (gt_div == 3'd5), 1'b0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    wait_drain();
    check("busy_final_div", gt_div, 3'd6);

    // 5. reset in the middle of CLR_REL
    send(3'd4);
    repeat (10) @(negedge clk);
    clr = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    model_div = RESET_DIV;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    watch_init();

`ifdef BUFG_GT_RATIO_CHK_EN
    // 6. ratio checker: good buffer, then a buffer dividing by 4 for DIV=2
    send(3'd2);
    wait_drain();
    send(3'd1);
    wait_drain();
    force_wrong = 1'b1;
    send(3'd2);
    wait_drain();
    repeat (3) @(negedge clk);
    check("err_sticky", bus.err, 1'b1);
    force_wrong = 1'b0;
    send(3'd5);
    check("err_cleared_on_accept", bus.err, 1'b0);
    wait_drain();
`endif

    // random stream, including same-DIV and back-to-back requests
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) d = model_div;
      else d = 3'($urandom_range(0, 7));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      send(d);
    end
    wait_drain();
    check("final_gt_div", gt_div, model_div);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
